reg_files_mp: RTL and testbench

Parametrised multi-port register file with write-back bypass, a per-register busy scoreboard and a post-reset clearing sweep. It replaces the fixed 3-read/1-write register file in the pipeline CPU decode stage. It lets wider issue configurations share one array and stall on operands whose producer has not yet written back.

---
 rtl/reg_files_mp.sv | 82 ++++++++
 tb/tb_reg_files_mp.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_files_mp.sv
// reg_files_mp: multi-port register file with write-back bypass, busy scoreboard and post-reset clearing sweep
module reg_files_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic [NUM_WRITE-1:0]           we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wd,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic                           ready
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic                  w_run;
  // state register: reset always restarts the sweep
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next;
  end
  // leave CLEAR once the last register has been zeroed
  always_comb begin
    w_next = (r_state == S_CLEAR && &r_cnt) ? S_RUN : r_state;
  end
  // outputs decoded from state
  always_comb begin
    w_run = (r_state == S_RUN);
    ready = w_run;
  end
  // sweep counter, advances only while clearing with rst low
  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
  end
  // array and scoreboard update; later assignments win, so higher write ports and issues take priority
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_CLEAR) begin
      r_rf[r_cnt]   <= '0;
      r_busy[r_cnt] <= 1'b0;
    end else if (!rst && w_run) begin
      for (int j = 0; j < NUM_WRITE; j++)
        if (we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
          r_rf[wa[j*ADDR_WIDTH +: ADDR_WIDTH]]   <= wd[j*DATA_WIDTH +: DATA_WIDTH];
          r_busy[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      if (iss_valid && iss_addr != '0) r_busy[iss_addr] <= 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_busy;
    assign w_ra = ra[k*ADDR_WIDTH +: ADDR_WIDTH];
    // asynchronous read with bypass from the highest matching write port, which also hides the busy bit
    always_comb begin
      w_rd   = r_rf[w_ra];
      w_busy = r_busy[w_ra];
      for (int j = 0; j < NUM_WRITE; j++)
        if (we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] == w_ra) begin
          w_rd   = wd[j*DATA_WIDTH +: DATA_WIDTH];
          w_busy = 1'b0;
        end
      if (!w_run || w_ra == '0) begin
        w_rd   = '0;
        w_busy = 1'b0;
      end
    end
    assign rd[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rbusy[k] = w_busy;
  end
endmodule

// File: tb/tb_reg_files_mp.sv
// tb_reg_files_mp: directed checks of sweep, bypass, register 0, scoreboard and reset behaviour
module tb_reg_files_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] ra;
  logic [95:0] rd;
  logic [2:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        ready;
  int n_chk = 0;
  int n_fail = 0;

  reg_files_mp dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy), .we(we), .wa(wa),
    .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 32) begin
        we = 2'b00;
        iss_valid = 1'b0;
      end
      chk(tag, {95'b0, ready}, {95'b0, i == 32});
    end
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a), 5'(a));
      #1;
      chk(tag, {rd, 3'b0} | {93'b0, rbusy}, 96'b0);
    end
  endtask

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
    set_ra(5'd1, 5'd2, 5'd3);
    repeat (3) tick();
    chk("reset_ready", {95'b0, ready}, 96'b0);
    chk("reset_rd", rd, 96'b0);
    chk("reset_rbusy", {93'b0, rbusy}, 96'b0);
    // release rst while hammering r9 with writes and issues that must be dropped
    rst = 1'b0;
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h12345678};
    iss_valid = 1'b1; iss_addr = 5'd9;
    set_ra(5'd9, 5'd9, 5'd9);
    sweep_check("sweep_ready");
    #1;
    chk("clear_r9", rd[31:0], 96'b0);
    chk("clear_r9_busy", {95'b0, rbusy[0]}, 96'b0);
    all_zero("sweep_zero");

    // bypass priority: port 1 wins
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h5555FFFF, 32'hAAAA0000};
    set_ra(5'd5, 5'd5, 5'd6);
    #1;
    chk("bypass_prio", rd[31:0], 96'h5555FFFF);
    chk("bypass_other", rd[95:64], 96'h0);
    tick();
    we = 2'b00;
    #1;
    chk("array_prio", rd[31:0], 96'h5555FFFF);

    // register 0 ignores writes and issues
    we = 2'b01; wa = 10'd0; wd = {32'd0, 32'hDEADBEEF};
    iss_valid = 1'b1; iss_addr = 5'd0;
    set_ra(5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_rd_same", rd, 96'b0);
    chk("r0_busy_same", {93'b0, rbusy}, 96'b0);
    tick();
    we = 2'b00; iss_valid = 1'b0;
    #1;
    chk("r0_rd_next", rd, 96'b0);
    chk("r0_busy_next", {93'b0, rbusy}, 96'b0);

    // scoreboard: issue r7
    set_ra(5'd7, 5'd5, 5'd7);
    iss_valid = 1'b1; iss_addr = 5'd7;
    #1;
    chk("iss_same_cycle", {93'b0, rbusy}, 96'b0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("iss_next_cycle", {93'b0, rbusy}, 96'b101);
    // write-back on port 1 clears combinationally
    we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h00000077, 32'h0};
    #1;
    chk("wb_busy_same", {93'b0, rbusy}, 96'b0);
    chk("wb_rd_same", rd[31:0], 96'h77);
    tick();
    we = 2'b00;
    #1;
    chk("wb_busy_next", {93'b0, rbusy}, 96'b0);
    chk("wb_rd_next", rd[95:64], 96'h77);
    // issue and write together: the new producer wins
    iss_valid = 1'b1; iss_addr = 5'd7;
    we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h00000088, 32'h0};
    #1;
    chk("setclr_same", {93'b0, rbusy}, 96'b0);
    tick();
    we = 2'b00; iss_valid = 1'b0;
    #1;
    chk("setclr_next", {93'b0, rbusy}, 96'b101);
    chk("setclr_rd", rd[31:0], 96'h88);

    // fill r1..r31 with their index, then mark r3 busy
    for (int a = 1; a < 32; a++) begin
      we = 2'b01; wa = {5'd0, 5'(a)}; wd = {32'd0, 32'(a)};
      tick();
    end
    we = 2'b00;
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_valid = 1'b0;
    set_ra(5'd3, 5'd31, 5'd17);
    #1;
    chk("fill_rd", rd, {32'd17, 32'd31, 32'd3});
    chk("fill_busy", {93'b0, rbusy}, 96'b001);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {95'b0, ready}, 96'b0);
    chk("midrst_rd", rd, 96'b0);
    sweep_check("resweep_ready");
    all_zero("resweep_zero");
    set_ra(5'd3, 5'd3, 5'd3);
    #1;
    chk("r3_not_busy", {93'b0, rbusy}, 96'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
